// File: rtl/soc_nios2_master_cpu_ocimem_arbiter.sv
// soc_nios2_master_cpu_ocimem_arbiter
//   Shares the on-chip debug monitor RAM (OCIMEM) between the JTAG debug slave
//   (sysclk-domain take_action strobes) and the CPU's Avalon debug-memory port.
//   Sequences every RAM access, keeps a post-incrementing JTAG address pointer
//   and returns JTAG read data on MonDReg.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   jtag_ld_addr / jdo_addr      load the JTAG pointer
//   jtag_acc / jtag_wr / jtag_wdata   JTAG access request at the pointer
//   MonDReg                      last JTAG read data
//   jtag_busy / jtag_ovf         JTAG pending-or-in-flight / sticky dropped pulse
//   av_*                         Avalon debug-memory slave (word addressed)
//   ram_*                        OCIMEM port (synchronous read, 1-cycle latency)
//
// Configuration
//   OCIMEM_JTAG_PRIORITY_EN  defined: JTAG always wins a tie (fixed priority).
//                            undefined: round-robin on ties.
module soc_nios2_master_cpu_ocimem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            jtag_ld_addr,
  input  logic            jtag_acc,
  input  logic            jtag_wr,
  input  logic [AW-1:0]   jdo_addr,
  input  logic [DW-1:0]   jtag_wdata,
  output logic [DW-1:0]   MonDReg,
  output logic            jtag_busy,
  output logic            jtag_ovf,
  input  logic [AW-1:0]   av_address,
  input  logic            av_read,
  input  logic            av_write,
  input  logic [DW/8-1:0] av_byteenable,
  input  logic [DW-1:0]   av_writedata,
  output logic [DW-1:0]   av_readdata,
  output logic            av_waitrequest,
  output logic [AW-1:0]   ram_address,
  output logic            ram_wren,
  output logic [DW/8-1:0] ram_byteenable,
  output logic [DW-1:0]   ram_wrdata,
  input  logic [DW-1:0]   ram_rddata
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JTAG_ACC,
    ST_JTAG_RD,
    ST_AV_ACC,
    ST_AV_RD
  } state_t;

  state_t        state_q, state_d;
  logic          jtag_pend_q;
  logic          jtag_wr_q;
  logic [DW-1:0] jtag_wdata_q;
  logic [AW-1:0] ptr_q;
  logic [DW-1:0] mon_q;
  logic          ovf_q;
  logic          av_wr_q;
`ifndef OCIMEM_JTAG_PRIORITY_EN
  logic          last_grant_jtag_q;  // 0 = Avalon had the last grant
`endif

  logic av_req;
  logic grant_jtag;
  logic grant_av;
  logic jtag_done;
  logic av_done;

  assign av_req         = av_read | av_write;
  assign av_waitrequest = av_req & ~av_done;
  assign MonDReg        = mon_q;
  assign jtag_busy      = jtag_pend_q;
  assign jtag_ovf       = ovf_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Arbitration, next state and RAM port decode
  always_comb begin
    state_d        = state_q;
    grant_jtag     = 1'b0;
    grant_av       = 1'b0;
    jtag_done      = 1'b0;
    av_done        = 1'b0;
    ram_address    = '0;
    ram_wren       = 1'b0;
    ram_byteenable = '0;
    ram_wrdata     = '0;
    av_readdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (jtag_pend_q && av_req) begin
`ifdef OCIMEM_JTAG_PRIORITY_EN
          grant_jtag = 1'b1;
`else
          grant_jtag = ~last_grant_jtag_q;
          grant_av   = last_grant_jtag_q;
`endif
        end else begin
          grant_jtag = jtag_pend_q;
          grant_av   = av_req;
        end
        if (grant_jtag)    state_d = ST_JTAG_ACC;
        else if (grant_av) state_d = ST_AV_ACC;
      end
      ST_JTAG_ACC: begin
        ram_address    = ptr_q;
        ram_byteenable = '1;
        ram_wrdata     = jtag_wdata_q;
        if (jtag_wr_q) begin
          ram_wren  = 1'b1;
          jtag_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_JTAG_RD;
        end
      end
      ST_JTAG_RD: begin
        jtag_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_AV_ACC: begin
        ram_address    = av_address;
        ram_byteenable = av_byteenable;
        ram_wrdata     = av_writedata;
        // Direction is latched at grant so a dropped request still completes.
        if (av_wr_q) begin
          ram_wren = 1'b1;
          av_done  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_AV_RD;
        end
      end
      ST_AV_RD: begin
        av_readdata = ram_rddata;
        av_done     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // JTAG request capture, pointer and overflow tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_wdata_q <= '0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      // Completion only occurs while pending, so it never collides with a load.
      if (jtag_done) begin
        jtag_pend_q <= 1'b0;
        ptr_q       <= ptr_q + AW'(1);
      end
      if (jtag_pend_q) begin
        if (jtag_acc || jtag_ld_addr) ovf_q <= 1'b1;
      end else begin
        if (jtag_ld_addr) begin
          ptr_q <= jdo_addr;
          ovf_q <= 1'b0;
        end
        if (jtag_acc) begin
          jtag_pend_q  <= 1'b1;
          jtag_wr_q    <= jtag_wr;
          jtag_wdata_q <= jtag_wdata;
        end
      end
    end
  end

  // Read-data return, Avalon direction latch and grant history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_q   <= '0;
      av_wr_q <= 1'b0;
`ifndef OCIMEM_JTAG_PRIORITY_EN
      last_grant_jtag_q <= 1'b0;
`endif
    end else begin
      if (state_q == ST_JTAG_RD) mon_q <= ram_rddata;
      if (grant_av) av_wr_q <= av_write;
`ifndef OCIMEM_JTAG_PRIORITY_EN
      if (grant_jtag)    last_grant_jtag_q <= 1'b1;
      else if (grant_av) last_grant_jtag_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_soc_nios2_master_cpu_ocimem_arbiter.sv
// Testbench for soc_nios2_master_cpu_ocimem_arbiter: table of directed
// Avalon/JTAG transactions plus hand-written arbitration, overflow and
// mid-access reset sequences. Drives on the falling edge, samples 1 ns later.
module tb_soc_nios2_master_cpu_ocimem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          jtag_ld_addr, jtag_acc, jtag_wr;
  logic [AW-1:0] jdo_addr;
  logic [DW-1:0] jtag_wdata;
  logic [DW-1:0] MonDReg;
  logic          jtag_busy, jtag_ovf;
  logic [AW-1:0] av_address;
  logic          av_read, av_write;
  logic [BW-1:0] av_byteenable;
  logic [DW-1:0] av_writedata;
  logic [DW-1:0] av_readdata;
  logic          av_waitrequest;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [BW-1:0] ram_byteenable;
  logic [DW-1:0] ram_wrdata;
  logic [DW-1:0] ram_rddata;

  soc_nios2_master_cpu_ocimem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_ld_addr(jtag_ld_addr), .jtag_acc(jtag_acc), .jtag_wr(jtag_wr),
    .jdo_addr(jdo_addr), .jtag_wdata(jtag_wdata), .MonDReg(MonDReg),
    .jtag_busy(jtag_busy), .jtag_ovf(jtag_ovf),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_byteenable(av_byteenable), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_address(ram_address), .ram_wren(ram_wren),
    .ram_byteenable(ram_byteenable), .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  // Behavioural OCIMEM: byte-enabled write, 1-cycle synchronous read
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < int'(BW); b++)
        if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_wrdata[8*b +: 8];
    ram_rddata <= mem[ram_address];
  end

  // Write-strobe monitor
  int            wren_cnt = 0;
  logic [AW-1:0] wren_addr = '0;
  always @(posedge clk) begin
    if (ram_wren) begin
      wren_cnt  <= wren_cnt + 1;
      wren_addr <= ram_address;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  typedef enum logic [2:0] {OP_AVW, OP_AVR, OP_JLD, OP_JWR, OP_JRD} op_t;
  // exp: read data for reads, expected RAM write address for JTAG writes
  typedef struct {
    op_t         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    int          exp_stalls;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic av_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int stalls,
                         output logic [31:0] rd, output bit ok);
    stalls = 0; ok = 1'b0; rd = '0;
    @(negedge clk);
    av_address = a; av_writedata = d; av_byteenable = be;
    av_write = wr; av_read = ~wr;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!av_waitrequest) begin ok = 1'b1; rd = av_readdata; break; end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic jtag_ld(input logic [7:0] a);
    @(negedge clk);
    jtag_ld_addr = 1'b1; jdo_addr = a;
    @(negedge clk);
    jtag_ld_addr = 1'b0;
  endtask

  // Pulses jtag_acc and waits for jtag_busy to clear; lat = negedges seen busy
  task automatic jtag_op(input logic wr, input logic [31:0] d, output int lat, output bit ok);
    @(negedge clk);
    jtag_acc = 1'b1; jtag_wr = wr; jtag_wdata = d;
    @(negedge clk);
    jtag_acc = 1'b0;
    ok = 1'b0; lat = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!jtag_busy) begin ok = 1'b1; break; end
      lat++;
      @(negedge clk);
    end
  endtask

  // JTAG read and Avalon read pending together; returns completion cycles
  task automatic tie_round(input logic [7:0] aaddr, output int jd, output int ad,
                           output logic [31:0] rd);
    jd = -1; ad = -1; rd = '0;
    @(negedge clk);
    jtag_acc = 1'b1; jtag_wr = 1'b0;
    @(negedge clk);
    jtag_acc = 1'b0; av_address = aaddr; av_read = 1'b1;
    for (int c = 1; c < 40 && (jd < 0 || ad < 0); c++) begin
      #1;
      if (ad < 0 && !av_waitrequest) begin ad = c; rd = av_readdata; end
      if (jd < 0 && !jtag_busy) jd = c;
      @(negedge clk);
      if (ad >= 0) av_read = 1'b0;
    end
    av_read = 1'b0;
  endtask

  initial begin
    int          stalls, lat, n0, jd, ad;
    logic [31:0] rd;
    bit          ok;
    bit          exp_jtag_first;

    vecs[0]  = '{OP_AVW, 8'h00, 32'hCAFEF00D, 4'hF, 32'h0,        1};
    vecs[1]  = '{OP_AVW, 8'h01, 32'h0BADF00D, 4'hF, 32'h0,        1};
    vecs[2]  = '{OP_AVW, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1};
    vecs[3]  = '{OP_AVR, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF, 2};
    vecs[4]  = '{OP_AVW, 8'h11, 32'hAAAA5555, 4'h3, 32'h0,        1};
    vecs[5]  = '{OP_AVW, 8'h11, 32'h1234FFFF, 4'hC, 32'h0,        1};
    vecs[6]  = '{OP_AVR, 8'h11, 32'h0,        4'hF, 32'h12345555, 2};
    vecs[7]  = '{OP_JLD, 8'hFF, 32'h0,        4'h0, 32'h0,        0};
    vecs[8]  = '{OP_JWR, 8'h00, 32'h12345678, 4'h0, 32'h000000FF, 0};
    vecs[9]  = '{OP_JRD, 8'h00, 32'h0,        4'h0, 32'hCAFEF00D, 0};
    vecs[10] = '{OP_AVR, 8'hFF, 32'h0,        4'hF, 32'h12345678, 2};
    vecs[11] = '{OP_JRD, 8'h00, 32'h0,        4'h0, 32'h0BADF00D, 0};
    vecs[12] = '{OP_JLD, 8'h10, 32'h0,        4'h0, 32'h0,        0};
    vecs[13] = '{OP_JRD, 8'h00, 32'h0,        4'h0, 32'hDEADBEEF, 0};
    vecs[14] = '{OP_JWR, 8'h00, 32'h5A5A5A5A, 4'h0, 32'h00000011, 0};
    vecs[15] = '{OP_AVR, 8'h11, 32'h0,        4'hF, 32'h5A5A5A5A, 2};

    reset_n = 1'b0;
    jtag_ld_addr = 1'b0; jtag_acc = 1'b0; jtag_wr = 1'b0;
    jdo_addr = '0; jtag_wdata = '0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_byteenable = '0; av_writedata = '0;

    // Reset state
    #1;
    chk("reset MonDReg", MonDReg, 32'h0);
    chk("reset waitrequest", 32'(av_waitrequest), 32'h0);
    chk("reset ram_wren", 32'(ram_wren), 32'h0);
    chk("reset jtag_busy", 32'(jtag_busy), 32'h0);
    chk("reset jtag_ovf", 32'(jtag_ovf), 32'h0);
    chk("reset av_readdata", av_readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed transaction table
    for (int i = 0; i < NV; i++) begin
      n0 = wren_cnt;
      case (vecs[i].op)
        OP_AVW: begin
          av_xfer(1'b1, vecs[i].addr, vecs[i].data, vecs[i].be, stalls, rd, ok);
          chk($sformatf("v%0d avw done", i), 32'(ok), 32'h1);
          chk($sformatf("v%0d avw stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
          chk($sformatf("v%0d avw wren count", i), 32'(wren_cnt - n0), 32'h1);
          chk($sformatf("v%0d avw wren addr", i), 32'(wren_addr), 32'(vecs[i].addr));
        end
        OP_AVR: begin
          av_xfer(1'b0, vecs[i].addr, 32'h0, vecs[i].be, stalls, rd, ok);
          chk($sformatf("v%0d avr done", i), 32'(ok), 32'h1);
          chk($sformatf("v%0d avr stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
          chk($sformatf("v%0d avr data", i), rd, vecs[i].exp);
          chk($sformatf("v%0d avr no wren", i), 32'(wren_cnt - n0), 32'h0);
        end
        OP_JLD: begin
          jtag_ld(vecs[i].addr);
          #1;
          chk($sformatf("v%0d jld busy", i), 32'(jtag_busy), 32'h0);
          chk($sformatf("v%0d jld ovf", i), 32'(jtag_ovf), 32'h0);
        end
        OP_JWR: begin
          jtag_op(1'b1, vecs[i].data, lat, ok);
          chk($sformatf("v%0d jwr done", i), 32'(ok), 32'h1);
          chk($sformatf("v%0d jwr busy cycles", i), 32'(lat), 32'h2);
          chk($sformatf("v%0d jwr wren count", i), 32'(wren_cnt - n0), 32'h1);
          chk($sformatf("v%0d jwr wren addr", i), 32'(wren_addr), vecs[i].exp);
        end
        OP_JRD: begin
          jtag_op(1'b0, 32'h0, lat, ok);
          chk($sformatf("v%0d jrd done", i), 32'(ok), 32'h1);
          chk($sformatf("v%0d jrd busy cycles", i), 32'(lat), 32'h3);
          chk($sformatf("v%0d jrd MonDReg", i), MonDReg, vecs[i].exp);
        end
        default: ;
      endcase
    end
    chk("jtag write data in ram 0xFF", mem[8'hFF], 32'h12345678);

    // Ties after an Avalon grant: JTAG first, twice (J, A, J, A)
    for (int r = 0; r < 2; r++) begin
      tie_round(8'h10, jd, ad, rd);
      chk($sformatf("tie%0d jtag completed", r), 32'(jd >= 0), 32'h1);
      chk($sformatf("tie%0d av completed", r), 32'(ad >= 0), 32'h1);
      chk($sformatf("tie%0d jtag before av", r), 32'(jd < ad), 32'h1);
      chk($sformatf("tie%0d av data", r), rd, 32'hDEADBEEF);
    end

    // Tie right after a JTAG grant: round-robin hands it to Avalon
`ifdef OCIMEM_JTAG_PRIORITY_EN
    exp_jtag_first = 1'b1;
`else
    exp_jtag_first = 1'b0;
`endif
    jtag_op(1'b0, 32'h0, lat, ok);
    chk("solo jtag done", 32'(ok), 32'h1);
    tie_round(8'h00, jd, ad, rd);
    chk("tie after jtag completed", 32'(jd >= 0 && ad >= 0), 32'h1);
    chk("tie after jtag order", 32'(jd < ad), 32'(exp_jtag_first));
    chk("tie after jtag av data", rd, 32'hCAFEF00D);

    // Two JTAG pulses one cycle apart: one access, overflow flagged
    jtag_ld(8'h20);
    n0 = wren_cnt;
    @(negedge clk); jtag_acc = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h11111111;
    @(negedge clk); jtag_acc = 1'b0;
    @(negedge clk); jtag_acc = 1'b1; jtag_wdata = 32'h22222222;
    @(negedge clk); jtag_acc = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("dbl pulse busy cleared", 32'(jtag_busy), 32'h0);
    chk("dbl pulse one access", 32'(wren_cnt - n0), 32'h1);
    chk("dbl pulse addr", 32'(wren_addr), 32'h20);
    chk("dbl pulse data", mem[8'h20], 32'h11111111);
    chk("dbl pulse ovf set", 32'(jtag_ovf), 32'h1);
    jtag_ld(8'h30);
    #1;
    chk("ld clears ovf", 32'(jtag_ovf), 32'h0);

    // Pointer load while busy is ignored
    @(negedge clk); jtag_acc = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h33333333;
    @(negedge clk); jtag_acc = 1'b0; jtag_ld_addr = 1'b1; jdo_addr = 8'h40;
    @(negedge clk); jtag_ld_addr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("ld while busy ovf", 32'(jtag_ovf), 32'h1);
    chk("write before ignored ld", 32'(wren_addr), 32'h30);
    jtag_op(1'b1, 32'h44444444, lat, ok);
    chk("pointer kept after ignored ld", 32'(wren_addr), 32'h31);

    // Reset during AV_RD
    jtag_ld(8'h10);
    jtag_op(1'b0, 32'h0, lat, ok);
    chk("pre-reset MonDReg", MonDReg, 32'hDEADBEEF);
    @(negedge clk); av_address = 8'h00; av_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("in AV_RD waitrequest low", 32'(av_waitrequest), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst waitrequest held read", 32'(av_waitrequest), 32'h1);
    chk("rst MonDReg", MonDReg, 32'h0);
    chk("rst ram_wren", 32'(ram_wren), 32'h0);
    chk("rst av_readdata", av_readdata, 32'h0);
    n0 = wren_cnt;
    repeat (3) @(negedge clk);
    chk("rst no writes", 32'(wren_cnt - n0), 32'h0);
    reset_n = 1'b1;
    stalls = 0; ok = 1'b0; rd = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!av_waitrequest) begin ok = 1'b1; rd = av_readdata; break; end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk); av_read = 1'b0;
    chk("post-reset read done", 32'(ok), 32'h1);
    chk("post-reset read stalls", 32'(stalls), 32'h2);
    chk("post-reset read data", rd, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required bench completion");
    $fatal(1, "time limit");
  end

endmodule
